// File: rtl/nec_ir_receiver.sv
// NEC IR receiver: synchronise/deglitch IRDA_RXD, measure mark/space widths in us ticks, decode 32-bit frames and repeats.
// Result pulses assert 1 clock after the filtered edge ending the stop mark; no backpressure, pulses are fire-and-forget.
module nec_ir_receiver #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int FILT_CYC   = 8,
    parameter bit CHECK_ADDR = 1'b1,
    parameter bit REPEAT_EN  = 1'b1,
    parameter int REPEAT_MS  = 120,
    // Divides every microsecond threshold and the repeat window; 1 gives real NEC timing.
    parameter int TIME_SCALE = 1
) (
    input  logic        CLOCK_50,
    input  logic        RESET,
    input  logic        IRDA_RXD,
    output logic [15:0] ir_addr,
    output logic [7:0]  ir_cmd,
    output logic        ir_valid,
    output logic        ir_repeat,
    output logic        ir_error,
    output logic        ir_busy,
    output logic [7:0]  LEDR
);
    localparam int US_DIV    = (CLK_HZ / 1_000_000 > 0) ? CLK_HZ / 1_000_000 : 1;
    localparam int PRE_W     = (US_DIV > 1) ? $clog2(US_DIV) : 1;
    localparam int FILT_W    = $clog2(FILT_CYC + 1);
    localparam int WIN_TICKS = REPEAT_MS * 1000 / TIME_SCALE;
    localparam int WIN_W     = $clog2(WIN_TICKS + 1);

    localparam logic [13:0] LEAD_LO = 14'(8000 / TIME_SCALE);
    localparam logic [13:0] LEAD_HI = 14'(10000 / TIME_SCALE);
    localparam logic [13:0] SPCD_LO = 14'(4000 / TIME_SCALE);
    localparam logic [13:0] SPCD_HI = 14'(5000 / TIME_SCALE);
    localparam logic [13:0] SPCR_LO = 14'(1900 / TIME_SCALE);
    localparam logic [13:0] SPCR_HI = 14'(2600 / TIME_SCALE);
    localparam logic [13:0] MARK_LO = 14'(350 / TIME_SCALE);
    localparam logic [13:0] MARK_HI = 14'(800 / TIME_SCALE);
    localparam logic [13:0] ONE_LO  = 14'(1400 / TIME_SCALE);
    localparam logic [13:0] ONE_HI  = 14'(1900 / TIME_SCALE);
    localparam logic [13:0] TIMEOUT = 14'(10000 / TIME_SCALE + 1);

    typedef enum logic [2:0] {
        IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK
    } state_t;

    logic [1:0]        sync_q;
    logic              filt_q;
    logic [FILT_W-1:0] fcnt_q;
    logic [PRE_W-1:0]  pre_q;
    logic [13:0]       width_q;
    state_t            state_q, state_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [31:0]       shreg_q, shreg_d;
    logic              rep_q, rep_d;
    logic              win_open_q;
    logic [WIN_W-1:0]  win_cnt_q;
    logic [15:0]       addr_q, addr_d;
    logic [7:0]        cmd_q, cmd_d;
    logic              valid_q, valid_d, repeat_q, repeat_d, error_q, error_d;
    logic              win_start;
    logic              edge_w, fall_w, rise_w, tick_w;
    logic              is_lead, is_spcd, is_spcr, is_mark, is_one, cmd_ok, addr_ok;

    function automatic logic in_rng(input logic [13:0] w, input logic [13:0] lo, input logic [13:0] hi);
        return (w >= lo) && (w <= hi);
    endfunction

    // Edge fires on the cycle the filtered level flips, so width_q still holds the just-ended interval.
    assign edge_w = (sync_q[1] != filt_q) && (fcnt_q == FILT_W'(FILT_CYC - 1));
    assign fall_w = edge_w && filt_q;
    assign rise_w = edge_w && !filt_q;
    assign tick_w = (pre_q == PRE_W'(US_DIV - 1));

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            sync_q  <= 2'b11;
            filt_q  <= 1'b1;
            fcnt_q  <= '0;
            pre_q   <= '0;
            width_q <= '0;
        end else begin
            sync_q <= {sync_q[0], IRDA_RXD};
            if (sync_q[1] == filt_q) begin
                fcnt_q <= '0;
            end else if (edge_w) begin
                filt_q <= sync_q[1];
                fcnt_q <= '0;
            end else begin
                fcnt_q <= fcnt_q + 1'b1;
            end
            pre_q <= tick_w ? '0 : pre_q + 1'b1;
            if (edge_w) begin
                width_q <= '0;
            end else if (tick_w && width_q != 14'h3FFF) begin
                width_q <= width_q + 14'd1;
            end
        end
    end

    assign is_lead = in_rng(width_q, LEAD_LO, LEAD_HI);
    assign is_spcd = in_rng(width_q, SPCD_LO, SPCD_HI);
    assign is_spcr = in_rng(width_q, SPCR_LO, SPCR_HI);
    assign is_mark = in_rng(width_q, MARK_LO, MARK_HI);
    assign is_one  = in_rng(width_q, ONE_LO, ONE_HI);
    assign cmd_ok  = (shreg_q[31:24] == ~shreg_q[23:16]);
    assign addr_ok = !CHECK_ADDR || (shreg_q[15:8] == ~shreg_q[7:0]);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        rep_d     = rep_q;
        addr_d    = addr_q;
        cmd_d     = cmd_q;
        valid_d   = 1'b0;
        repeat_d  = 1'b0;
        error_d   = 1'b0;
        win_start = 1'b0;
        if (state_q != IDLE && width_q >= TIMEOUT) begin
            error_d = 1'b1;
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (fall_w) begin
                    state_d = LEAD_MARK;
                    rep_d   = 1'b0;
                end
                LEAD_MARK: if (rise_w) begin
                    if (is_lead) state_d = LEAD_SPACE;
                    else begin error_d = 1'b1; state_d = IDLE; end
                end
                LEAD_SPACE: if (fall_w) begin
                    if (is_spcd) begin
                        state_d   = BIT_MARK;
                        bit_cnt_d = 5'd0;
                    end else if (is_spcr) begin
                        state_d = STOP_MARK;
                        rep_d   = 1'b1;
                    end else begin
                        error_d = 1'b1;
                        state_d = IDLE;
                    end
                end
                BIT_MARK: if (rise_w) begin
                    if (is_mark) state_d = BIT_SPACE;
                    else begin error_d = 1'b1; state_d = IDLE; end
                end
                BIT_SPACE: if (fall_w) begin
                    if (is_mark || is_one) begin
                        shreg_d = {is_one, shreg_q[31:1]};
                        if (bit_cnt_q == 5'd31) begin
                            state_d = STOP_MARK;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                            state_d   = BIT_MARK;
                        end
                    end else begin
                        error_d = 1'b1;
                        state_d = IDLE;
                    end
                end
                STOP_MARK: if (rise_w) begin
                    state_d = IDLE;
                    if (!is_mark) begin
                        error_d = 1'b1;
                    end else if (rep_q) begin
                        if (REPEAT_EN && win_open_q) begin
                            repeat_d  = 1'b1;
                            win_start = 1'b1;
                        end else begin
                            error_d = 1'b1;
                        end
                    end else if (cmd_ok && addr_ok) begin
                        valid_d   = 1'b1;
                        win_start = 1'b1;
                        addr_d    = CHECK_ADDR ? {8'h00, shreg_q[7:0]} : shreg_q[15:0];
                        cmd_d     = shreg_q[23:16];
                    end else begin
                        error_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            rep_q      <= 1'b0;
            addr_q     <= '0;
            cmd_q      <= '0;
            valid_q    <= 1'b0;
            repeat_q   <= 1'b0;
            error_q    <= 1'b0;
            win_open_q <= 1'b0;
            win_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            rep_q     <= rep_d;
            addr_q    <= addr_d;
            cmd_q     <= cmd_d;
            valid_q   <= valid_d;
            repeat_q  <= repeat_d;
            error_q   <= error_d;
            if (win_start) begin
                win_open_q <= 1'b1;
                win_cnt_q  <= '0;
            end else if (win_open_q && tick_w) begin
                if (win_cnt_q == WIN_W'(WIN_TICKS - 1)) win_open_q <= 1'b0;
                else win_cnt_q <= win_cnt_q + 1'b1;
            end
        end
    end

    assign ir_addr   = addr_q;
    assign ir_cmd    = cmd_q;
    assign LEDR      = cmd_q;
    assign ir_valid  = valid_q;
    assign ir_repeat = repeat_q;
    assign ir_error  = error_q;
    assign ir_busy   = (state_q != IDLE);
endmodule

// File: tb/tb_nec_ir_receiver.sv
// Two receivers (8-bit and extended addressing) share one IR line; every frame queues its expected result per receiver.
module tb_nec_ir_receiver;
    // 1 tick = 2 clocks, each tick stands for 50 us of real NEC time.
    localparam int T_LEAD = 360;
    localparam int T_LSPC = 180;
    localparam int T_RSPC = 90;
    localparam int T_MARK = 22;
    localparam int T_ZERO = 22;
    localparam int T_ONE  = 68;
    localparam int T_GAP  = 300;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic line_lvl = 1'b1;
    logic glitch = 1'b0;
    logic glitch_en = 1'b0;
    logic rxd;
    assign rxd = line_lvl ^ glitch;

    logic [15:0] a_addr, b_addr;
    logic [7:0]  a_cmd, b_cmd, a_led, b_led;
    logic        a_valid, a_repeat, a_error, a_busy;
    logic        b_valid, b_repeat, b_error, b_busy;

    nec_ir_receiver #(.CLK_HZ(2_000_000), .FILT_CYC(4), .CHECK_ADDR(1'b1), .REPEAT_EN(1'b1),
                      .REPEAT_MS(120), .TIME_SCALE(50)) dut_a (
        .CLOCK_50(clk), .RESET(rst), .IRDA_RXD(rxd), .ir_addr(a_addr), .ir_cmd(a_cmd),
        .ir_valid(a_valid), .ir_repeat(a_repeat), .ir_error(a_error), .ir_busy(a_busy), .LEDR(a_led));

    nec_ir_receiver #(.CLK_HZ(2_000_000), .FILT_CYC(4), .CHECK_ADDR(1'b0), .REPEAT_EN(1'b1),
                      .REPEAT_MS(120), .TIME_SCALE(50)) dut_b (
        .CLOCK_50(clk), .RESET(rst), .IRDA_RXD(rxd), .ir_addr(b_addr), .ir_cmd(b_cmd),
        .ir_valid(b_valid), .ir_repeat(b_repeat), .ir_error(b_error), .ir_busy(b_busy), .LEDR(b_led));

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] addr;
        logic [7:0]  cmd;
    } exp_t;

    localparam logic [1:0] K_VALID = 2'd1;
    localparam logic [1:0] K_REP   = 2'd2;
    localparam logic [1:0] K_ERR   = 2'd3;

    exp_t qa[$];
    exp_t qb[$];
    logic [15:0] la_addr = '0, lb_addr = '0;
    logic [7:0]  la_cmd = '0, lb_cmd = '0;
    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // A valid result updates the held addr/cmd; repeat and error expect the held values unchanged.
    task automatic push(input bit side_b, input logic [1:0] kind, input logic [15:0] addr, input logic [7:0] cmd);
        if (side_b) begin
            if (kind == K_VALID) begin lb_addr = addr; lb_cmd = cmd; end
            qb.push_back({kind, lb_addr, lb_cmd});
        end else begin
            if (kind == K_VALID) begin la_addr = addr; la_cmd = cmd; end
            qa.push_back({kind, la_addr, la_cmd});
        end
    endtask

    task automatic mon_one(input bit side_b, input logic v, input logic r, input logic e,
                           input logic [15:0] addr, input logic [7:0] cmd, input logic [7:0] led);
        exp_t x;
        logic [1:0] k;
        string s;
        s = side_b ? "B" : "A";
        if (v | r | e) begin
            check({s, " pulse_onehot"}, 32'($countones({v, r, e})), 32'd1);
            k = v ? K_VALID : (r ? K_REP : K_ERR);
            if ((side_b ? qb.size() : qa.size()) == 0) begin
                n_total++;
                $display("FAIL %s unexpected_pulse: got kind %0d, expected no pulse", s, k);
            end else begin
                x = side_b ? qb.pop_front() : qa.pop_front();
                check({s, " kind"}, 32'(k), 32'(x.kind));
                check({s, " ir_addr"}, 32'(addr), 32'(x.addr));
                check({s, " ir_cmd"}, 32'(cmd), 32'(x.cmd));
                check({s, " LEDR"}, 32'(led), 32'(x.cmd));
            end
        end
    endtask

    always @(negedge clk) begin
        mon_one(1'b0, a_valid, a_repeat, a_error, a_addr, a_cmd, a_led);
        mon_one(1'b1, b_valid, b_repeat, b_error, b_addr, b_cmd, b_led);
    end

    initial begin : glitch_gen
        int gcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            gcnt++;
            glitch = glitch_en && ((gcnt % 25) < 2);
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, " A busy"}, 32'(a_busy), 32'd0);
        check({tag, " B busy"}, 32'(b_busy), 32'd0);
        check({tag, " A addr"}, 32'(a_addr), 32'd0);
        check({tag, " B addr"}, 32'(b_addr), 32'd0);
        check({tag, " A cmd"}, 32'(a_cmd), 32'd0);
        check({tag, " B cmd"}, 32'(b_cmd), 32'd0);
        check({tag, " A LEDR"}, 32'(a_led), 32'd0);
        check({tag, " B LEDR"}, 32'(b_led), 32'd0);
        check({tag, " pulses"}, 32'({a_valid, a_repeat, a_error, b_valid, b_repeat, b_error}), 32'd0);
    endtask

    // abort_bit >= 0 pulls RESET just before that bit's mark.
    task automatic send_frame(input logic [31:0] data, input int abort_bit);
        line_lvl = 1'b0; clks(T_LEAD);
        line_lvl = 1'b1; clks(T_LSPC);
        for (int i = 0; i < 32; i++) begin
            if (i == abort_bit) begin
                check("midframe A busy", 32'(a_busy), 32'd1);
                check("midframe B busy", 32'(b_busy), 32'd1);
                rst = 1'b1;
                clks(1);
                check_reset_state("abort");
                clks(3);
                rst = 1'b0;
                la_addr = '0; la_cmd = '0; lb_addr = '0; lb_cmd = '0;
                clks(T_GAP);
                return;
            end
            line_lvl = 1'b0; clks(T_MARK);
            line_lvl = 1'b1; clks(data[i] ? T_ONE : T_ZERO);
        end
        line_lvl = 1'b0; clks(T_MARK);
        line_lvl = 1'b1; clks(T_GAP);
    endtask

    task automatic send_repeat();
        line_lvl = 1'b0; clks(T_LEAD);
        line_lvl = 1'b1; clks(T_RSPC);
        line_lvl = 1'b0; clks(T_MARK);
        line_lvl = 1'b1; clks(T_GAP);
    endtask

    initial begin
        clks(6);
        rst = 1'b0;
        clks(2);
        check_reset_state("reset");

        // addr 0x04 cmd 0x1A
        push(1'b0, K_VALID, 16'h0004, 8'h1A);
        push(1'b1, K_VALID, 16'hFB04, 8'h1A);
        send_frame(32'hE51AFB04, -1);

        // repeat 40 ms after the frame: inside the window
        clks(1300);
        push(1'b0, K_REP, '0, '0);
        push(1'b1, K_REP, '0, '0);
        send_repeat();

        // repeat 150 ms later: window closed
        clks(5700);
        push(1'b0, K_ERR, '0, '0);
        push(1'b1, K_ERR, '0, '0);
        send_repeat();

        // ~cmd byte corrupted at bit 24
        push(1'b0, K_ERR, '0, '0);
        push(1'b1, K_ERR, '0, '0);
        send_frame(32'hE51AFB04 ^ 32'h0100_0000, -1);

        // address 0xA55A: its bytes happen to be complementary, so 8-bit mode accepts it as 0x5A
        push(1'b0, K_VALID, 16'h005A, 8'h10);
        push(1'b1, K_VALID, 16'hA55A, 8'h10);
        send_frame(32'hEF10A55A, -1);

        // genuine extended address 0x1234: only the 16-bit receiver accepts
        push(1'b0, K_ERR, '0, '0);
        push(1'b1, K_VALID, 16'h1234, 8'h10);
        send_frame(32'hEF101234, -1);

        // short glitches throughout a valid frame
        glitch_en = 1'b1;
        push(1'b0, K_VALID, 16'h0004, 8'h1A);
        push(1'b1, K_VALID, 16'hFB04, 8'h1A);
        send_frame(32'hE51AFB04, -1);
        glitch_en = 1'b0;

        // 6 ms lead mark
        push(1'b0, K_ERR, '0, '0);
        push(1'b1, K_ERR, '0, '0);
        line_lvl = 1'b0; clks(240);
        line_lvl = 1'b1; clks(T_GAP);

        // reset at bit 15, then a clean frame addr 0x30 cmd 0xC7
        send_frame(32'hE51AFB04, 15);
        push(1'b0, K_VALID, 16'h0030, 8'hC7);
        push(1'b1, K_VALID, 16'hCF30, 8'hC7);
        send_frame(32'h38C7CF30, -1);

        clks(500);
        check("A results outstanding", 32'(qa.size()), 32'd0);
        check("B results outstanding", 32'(qb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
